// File: rtl/tx_serial_7e1.sv
// tx_serial_7e1: asynchronous serial transmitter, 7E1 framing
// (start, 7 data bits LSB-first, even parity, stop).
// One character is sent per rising edge of partida; pronto pulses at frame end.
// Optional build macro TX_SERIAL_TWO_STOP_EN adds a second stop bit (11-bit frame).
//
// state        | code | meaning
// -------------+------+---------------------------------------------------
// INICIAL      | 0000 | idle, line high, waiting for a partida rising edge
// PREPARACAO   | 0001 | latch character into frame, clear counters
// TRANSMISSAO  | 0101 | shift frame out, one bit every M clocks
// FINAL        | 1111 | one-cycle pronto pulse, then back to idle

module tx_serial_7e1 #(
    parameter int M = 5208,
    parameter int N = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto,
    output logic       db_clock,
    output logic       db_tick,
    output logic       db_partida,
    output logic       db_saida_serial,
    output logic [3:0] db_estado
);

`ifdef TX_SERIAL_TWO_STOP_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [3:0]   LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [N-1:0] TICK_MAX = N'(M - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARACAO  = 4'b0001,
        TRANSMISSAO = 4'b0101,
        FINAL       = 4'b1111
    } estado_t;

    estado_t               estado, estado_next;
    logic                  partida_q;
    logic                  start;
    logic                  tick;
    logic [N-1:0]          tick_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_load;
    logic                  saida_q;

    assign start = partida & ~partida_q;

`ifdef TX_SERIAL_TWO_STOP_EN
    assign frame_load = {2'b11, ^dados_ascii, dados_ascii, 1'b0};
`else
    assign frame_load = {1'b1, ^dados_ascii, dados_ascii, 1'b0};
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= estado_next;
    end

    // Next-state logic; start is only honoured while idle
    always_comb begin
        estado_next = estado;
        case (estado)
            INICIAL:     if (start) estado_next = PREPARACAO;
            PREPARACAO:  estado_next = TRANSMISSAO;
            TRANSMISSAO: if (tick && bit_cnt == LAST_BIT) estado_next = FINAL;
            FINAL:       estado_next = INICIAL;
            default:     estado_next = INICIAL;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        pronto    = (estado == FINAL);
        db_estado = estado;
        tick      = (estado == TRANSMISSAO) && (tick_cnt == TICK_MAX);
    end

    // Datapath: edge detector, baud counter, bit counter, shifter and the
    // registered line driver. saida_q tracks the next frame LSB so the line
    // changes exactly on the clock edge that shifts the frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            partida_q <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            frame_q   <= '0;
            saida_q   <= 1'b1;
        end else begin
            partida_q <= partida;
            case (estado)
                PREPARACAO: begin
                    frame_q  <= frame_load;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    saida_q  <= frame_load[0];
                end
                TRANSMISSAO: begin
                    if (tick) begin
                        tick_cnt <= '0;
                        frame_q  <= {1'b1, frame_q[FRAME_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        saida_q  <= frame_q[1];
                    end else begin
                        tick_cnt <= tick_cnt + N'(1);
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    saida_q  <= 1'b1;
                end
            endcase
        end
    end

    assign saida_serial    = saida_q;
    assign db_clock        = clock;
    assign db_tick         = tick;
    assign db_partida      = partida;
    assign db_saida_serial = saida_q;

endmodule

// File: tb/tb_tx_serial_7e1.sv
// Directed bench for tx_serial_7e1 with a shortened bit period (M=8).
`timescale 1ns/1ps

module tb_tx_serial_7e1;

    localparam int M = 8;
    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       partida = 1'b0;
    logic [6:0] dados_ascii = 7'h00;
    logic       saida_serial, pronto, db_clock, db_tick, db_partida, db_saida_serial;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;

    tx_serial_7e1 #(.M(M), .N(N)) dut (
        .clock           (clock),
        .reset           (reset),
        .partida         (partida),
        .dados_ascii     (dados_ascii),
        .saida_serial    (saida_serial),
        .pronto          (pronto),
        .db_clock        (db_clock),
        .db_tick         (db_tick),
        .db_partida      (db_partida),
        .db_saida_serial (db_saida_serial),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // seq holds the line values in transmit order, first bit at the MSB.
    // The cycle counter c is 1 just after the edge that samples the start
    // edge; bits occupy c = 2 .. 10*M+1, FINAL is c = 10*M+2.
    task automatic run_frame(input string name, input logic [6:0] ch,
                             input logic [9:0] seq, input int hold, input int reraise);
        int npronto = 0;
        int first   = 0;
        int nticks  = 0;
        int tail_bad = 0;
        int b, j;
        partida     = 1'b0;
        dados_ascii = ch;
        @(posedge clock); #1;
        partida = 1'b1;
        for (int c = 1; c <= 10*M + 30; c++) begin
            @(posedge clock); #1;
            if (c == 1) check({name, "_estado_prep"}, 32'(db_estado), 32'h1);
            if (c == 2) check({name, "_estado_tx"}, 32'(db_estado), 32'h5);
            if (c == 10*M + 2) check({name, "_estado_final"}, 32'(db_estado), 32'hF);
            if (c >= 2 && c <= 10*M + 1) begin
                b = (c - 2) / M;
                j = (c - 2) % M;
                if (j == 0 || j == M - 1)
                    check($sformatf("%s_bit%0d_%s", name, b, (j == 0) ? "first" : "last"),
                          32'(saida_serial), 32'(seq[9-b]));
            end
            if (pronto === 1'b1) begin
                npronto++;
                if (first == 0) first = c;
            end
            if (db_tick === 1'b1) nticks++;
            if (c > 10*M + 2 && (saida_serial !== 1'b1 || db_estado !== 4'h0)) tail_bad++;
            if (c == hold)    partida = 1'b0;
            if (c == reraise) partida = 1'b1;
            if (c == 3)       dados_ascii = ~ch;
        end
        check({name, "_pronto_count"}, 32'(npronto), 32'd1);
        check({name, "_pronto_cycle"}, 32'(first), 32'(10*M + 2));
        check({name, "_tick_count"}, 32'(nticks), 32'd10);
        check({name, "_idle_after"}, 32'(tail_bad), 32'd0);
    endtask

    initial begin
        int idle_bad;

        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("rst_saida", 32'(saida_serial), 32'd1);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_estado", 32'(db_estado), 32'h0);
        reset = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (saida_serial !== 1'b1 || db_estado !== 4'h0 || pronto !== 1'b0) idle_bad++;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);

        // partida held 25 cycles: one frame only
        run_frame("c35", 7'h35, 10'b0101011001, 25, 0);
        // partida drops early and rises again mid-transmission, then stays high
        run_frame("c55", 7'h55, 10'b0101010101, 4, 20);
        run_frame("c7e", 7'h7E, 10'b0011111101, 2, 0);
        check("db_partida", 32'(db_partida), 32'(partida));
        run_frame("c7f", 7'h7F, 10'b0111111111, 2, 0);

        // reset in the middle of a frame, during a low data bit
        partida     = 1'b0;
        dados_ascii = 7'h7E;
        @(posedge clock); #1;
        partida = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("midrst_before", 32'(saida_serial), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_saida", 32'(saida_serial), 32'd1);
        check("midrst_estado", 32'(db_estado), 32'h0);
        check("midrst_pronto", 32'(pronto), 32'd0);
        partida = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        run_frame("c35b", 7'h35, 10'b0101011001, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_serial_7e1.md
Name: tx_serial_7e1

Overview:
- Asynchronous serial transmitter, 7E1 format (1 start, 7 data LSB-first, even parity, 1 stop) at 9600 baud from a 50 MHz clock.
- Sends one ASCII character per rising edge of `partida` and flags completion on `pronto`.
- Sits between the character source and the UART TX pin; debug outputs feed board LEDs/7-segment.

Parameters:
- M, 5208, clock cycles per bit (50 MHz / 9600, truncated); minimum legal value 2.
- N, 13, width of the baud tick counter (must hold M-1).

Ports:
- clock  in  1  system clock, 50 MHz, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- partida  in  1  start request; only its rising edge is used.
- dados_ascii  in  7  character to send; sampled once, in the PREPARACAO state.
- saida_serial  out  1  serial line; idles high.
- pronto  out  1  end-of-frame pulse, one clock wide.
- db_clock  out  1  copy of clock.
- db_tick  out  1  internal baud tick.
- db_partida  out  1  copy of partida.
- db_saida_serial  out  1  copy of saida_serial.
- db_estado  out  4  FSM state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to INICIAL; shift register, bit counter and tick counter clear.
  - saida_serial=1, pronto=0, db_estado=0000.
  - Reset mid-frame aborts the frame immediately; the line returns high.
- Start edge detector: register partida; start = partida & ~partida_q. Holding partida high for many cycles triggers exactly one frame.
- FSM states, with db_estado codes:
  - INICIAL (0000): saida_serial=1. On start, go to PREPARACAO. Otherwise stay.
  - PREPARACAO (0001), one cycle:
    - Load the 10-bit frame {1, p, d6..d0, 0}, where p = XOR of d6..d0 (even parity).
    - Clear the tick counter and the bit counter.
    - Go to TRANSMISSAO.
  - TRANSMISSAO (0101):
    - saida_serial = frame LSB. The start bit appears on the cycle after PREPARACAO.
    - The tick counter counts 0..M-1; tick=1 when count=M-1, then it wraps to 0.
    - On each tick, shift the frame right, filling with 1, and increment the bit counter.
    - Every bit is held exactly M cycles.
    - When the tick ending bit 10 (stop) occurs, go to FINAL.
  - FINAL (1111), one cycle: pronto=1, saida_serial=1. Then go to INICIAL.
- start is ignored in PREPARACAO, TRANSMISSAO and FINAL; no queuing.
- If partida is still high on return to INICIAL, no new frame starts until partida falls and rises again.
- Timing:
  - Frame duration is 10*M cycles (52080, about 1.0417 ms).
  - pronto asserts 10*M+2 cycles after the clock edge that sampled start.
- Changes to dados_ascii after PREPARACAO do not affect the frame in progress.
- saida_serial is driven from a register; it must be glitch-free.
- db_tick pulses only in TRANSMISSAO.

Optional Feature:
- Macro: TX_SERIAL_TWO_STOP_EN.
- When defined:
  - The frame is 11 bits: {1, 1, p, d6..d0, 0}.
  - TRANSMISSAO ends after 11 ticks; frame duration is 11*M.
  - pronto asserts 11*M+2 cycles after start.
- When undefined: standard 1 stop bit, 10-bit frame as above.

Test Plan:
- Reset: assert reset=0 for 20 cycles, release → saida_serial=1, pronto=0, db_estado=0000. No activity for 50 idle cycles.
- dados_ascii=35h, partida held high 25 cycles:
  - Line sequence is 0,1,0,1,0,1,1,0,0,1, each bit 5208 cycles (parity 0).
  - pronto is one 1-cycle pulse; only one frame is sent.
- dados_ascii=55h → line 0,1,0,1,0,1,0,1,0,1 (parity 0). Bit-boundary spacing is exactly M cycles.
- dados_ascii=7Eh → line 0,0,1,1,1,1,1,1,0,1 (parity 0).
- dados_ascii=7Fh → line 0,1,1,1,1,1,1,1,1,1 (parity 1). pronto at 52082 cycles after start.
- Robustness:
  - A new partida edge during TRANSMISSAO is ignored.
  - reset=0 mid-frame → saida_serial=1 and db_estado=0000 immediately.
  - After release, the next partida edge sends a full new frame.
